store_processing_unit: RTL and testbench
========================================

STORE_PROCESSING_UNIT -- requirements
Module: store_processing_unit

Interface
REQ-001 Parameter DEPTH, default 2, is the store-buffer entry count; legal values are 2, 4 or 8.
REQ-002 CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 MEM_WRITE  in  1  store request from the MEM stage, valid this cycle.
REQ-005 FUNC3  in  3  store type: 000 SB, 001 SH, 010 SW.
REQ-006 ADDRESS  in  32  byte address of the store.
REQ-007 DATA_IN  in  32  rs2 value, with the store data in the low bits.
REQ-008 STALL  out  1  pipeline hold: store not accepted this cycle.
REQ-009 MISALIGNED  out  1  one-cycle flag marking a rejected misaligned store.
REQ-010 BUFFER_EMPTY  out  1  high when no store is buffered or in flight.
REQ-011 WRITE_REQ  out  1  memory write valid.
REQ-012 WRITE_ADDR  out  32  word-aligned address: ADDRESS[31:2] followed by 2'b00.
REQ-013 WRITE_DATA  out  32  lane-replicated store data.
REQ-014 BYTE_EN  out  4  byte-lane write enables.
REQ-015 MEM_ACK  in  1  memory accepts the write in any cycle where it is high together with WRITE_REQ.

Function
REQ-016 Lane encoding SHALL be:
- SB: BYTE_EN = 4'b0001 << ADDRESS[1:0]; WRITE_DATA = DATA_IN[7:0] replicated to all 4 bytes.
- SH: BYTE_EN = 4'b0011 << ADDRESS[1:0]; WRITE_DATA = DATA_IN[15:0] replicated twice.
- SW: BYTE_EN = 4'b1111; WRITE_DATA = DATA_IN.
REQ-017 A store SHALL be enqueued at the clock edge when MEM_WRITE=1, FUNC3 is legal, the access is not rejected as misaligned, and the buffer is not full.
REQ-018 MEM_WRITE=1 with FUNC3 not in {000, 001, 010} SHALL be ignored: no enqueue, no STALL, no MISALIGNED.
REQ-019 STALL SHALL be combinational and equal MEM_WRITE AND legal FUNC3 AND buffer full; a pop in the same cycle does not clear STALL.
REQ-020 The buffer SHALL be a FIFO, head first, with pointers that wrap modulo DEPTH; push and pop in the same cycle leave the count unchanged.
REQ-021 The issue FSM SHALL have two states:
- IDLE: WRITE_REQ=0; go to ISSUE on the cycle after the count becomes nonzero.
- ISSUE: WRITE_REQ=1 with the head entry driven; on MEM_ACK, pop the head; stay in ISSUE if entries remain, otherwise go to IDLE.
REQ-022 WRITE_ADDR, WRITE_DATA and BYTE_EN SHALL be held stable while WRITE_REQ=1 and MEM_ACK=0.
REQ-023 Minimum latency SHALL be one cycle: store accepted at edge N, WRITE_REQ high after edge N+1.
REQ-024 Throughput SHALL be one write per cycle while MEM_ACK is held high.
REQ-025 BUFFER_EMPTY SHALL be registered and high iff count is 0 and the FSM is in IDLE.

Reset
REQ-026 While RESET=1 at an edge, the unit SHALL clear the count and pointers and enter IDLE.
REQ-027 Reset output values SHALL be: WRITE_REQ=0, MISALIGNED=0, BUFFER_EMPTY=1, WRITE_ADDR=0, WRITE_DATA=0, BYTE_EN=0.
REQ-028 A reset during ISSUE SHALL discard all pending and in-flight entries, and no further WRITE_REQ SHALL be issued for them.
REQ-029 A store presented in the reset cycle SHALL NOT be enqueued.

Configuration
REQ-030 Macro STORE_MISALIGN_TRAP_EN, when defined, SHALL enable misalignment checking:
- SH with ADDRESS[0]=1, or SW with ADDRESS[1:0]!=0, is not enqueued.
- MISALIGNED pulses high for one cycle after that edge.
- STALL is not asserted for such a store.
REQ-031 When the macro is undefined, the unit SHALL tie MISALIGNED to 0 and force misaligned stores to natural alignment:
- SH ignores ADDRESS[0].
- SW ignores ADDRESS[1:0].

Verification
REQ-032 Bench scenario 1: SB, ADDRESS=0x1003, DATA_IN=0x000000AB, MEM_ACK=1 -> WRITE_ADDR=0x1000, BYTE_EN=1000, WRITE_DATA=0xABABABAB, BUFFER_EMPTY=1 two cycles later.
REQ-033 Bench scenario 2: SH at 0x2002, DATA_IN=0xFFFF1234 -> BYTE_EN=1100, WRITE_DATA=0x12341234; SW at 0x2004 -> BYTE_EN=1111, WRITE_DATA=DATA_IN.
REQ-034 Bench scenario 3: DEPTH=2, MEM_ACK=0, three back-to-back SW -> third store sees STALL=1; after MEM_ACK=1, the three stores are written in order 0x10, 0x14, 0x18.
REQ-035 Bench scenario 4: with STORE_MISALIGN_TRAP_EN, SW at 0x3001 -> MISALIGNED one-cycle pulse, no WRITE_REQ; without the macro -> write to 0x3000 with BYTE_EN=1111.
REQ-036 Bench scenario 5: RESET=1 while in ISSUE with two entries pending -> next cycle WRITE_REQ=0, BUFFER_EMPTY=1, and no later write occurs.
REQ-037 Bench scenario 6: FUNC3=011 with MEM_WRITE=1 -> no STALL, no enqueue, BUFFER_EMPTY stays 1.

Source files
------------

// File: rtl/store_processing_unit.sv
// Store buffer with a two-state issue FSM: encodes SB/SH/SW lanes, queues stores and drains them to memory.
// Optional feature macro STORE_MISALIGN_TRAP_EN rejects misaligned SH/SW instead of aligning them.
module store_processing_unit #(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] DATA_IN,
  output logic        STALL,
  output logic        MISALIGNED,
  output logic        BUFFER_EMPTY,
  output logic        WRITE_REQ,
  output logic [31:0] WRITE_ADDR,
  output logic [31:0] WRITE_DATA,
  output logic [3:0]  BYTE_EN,
  input  logic        MEM_ACK,
  output logic        DBG_STATE
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic { S_IDLE = 1'b0, S_ISSUE = 1'b1 } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            empty_q, empty_d;
  logic            mis_q, mis_d;

  logic [29:0]     addr_mem [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [3:0]      be_mem   [DEPTH];

  logic            is_sb, is_sh, is_sw, legal, mis, accept, full, push, pop;
  logic [1:0]      off;
  logic [3:0]      enc_be;
  logic [31:0]     enc_data;

  assign is_sb = (FUNC3 == 3'b000);
  assign is_sh = (FUNC3 == 3'b001);
  assign is_sw = (FUNC3 == 3'b010);
  assign legal = is_sb | is_sh | is_sw;

`ifdef STORE_MISALIGN_TRAP_EN
  assign mis = (is_sh & ADDRESS[0]) | (is_sw & (ADDRESS[1:0] != 2'b00));
  assign off = ADDRESS[1:0];
`else
  // Without trapping, misaligned halfwords/words are silently forced to natural alignment.
  assign mis = 1'b0;
  assign off = is_sw ? 2'b00 : (is_sh ? {ADDRESS[1], 1'b0} : ADDRESS[1:0]);
`endif

  always_comb begin
    enc_be   = 4'b0000;
    enc_data = DATA_IN;
    if (is_sb) begin
      enc_be   = 4'b0001 << off;
      enc_data = {4{DATA_IN[7:0]}};
    end else if (is_sh) begin
      enc_be   = 4'b0011 << off;
      enc_data = {2{DATA_IN[15:0]}};
    end else if (is_sw) begin
      enc_be   = 4'b1111;
      enc_data = DATA_IN;
    end
  end

  assign full   = (count_q == CW'(DEPTH));
  assign accept = MEM_WRITE & legal & ~mis;
  // A pop in the same cycle does not free a slot for the stalled store.
  assign STALL  = accept & full;
  assign push   = accept & ~full;
  assign pop    = (state_q == S_ISSUE) & MEM_ACK;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_ISSUE;
      S_ISSUE: if (pop && (count_d == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    empty_d = (count_d == '0) && (state_d == S_IDLE);
    mis_d   = MEM_WRITE & legal & mis;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty_q  <= 1'b1;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      mis_q    <= mis_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !RESET) begin
      addr_mem[wr_ptr_q] <= ADDRESS[31:2];
      data_mem[wr_ptr_q] <= enc_data;
      be_mem[wr_ptr_q]   <= enc_be;
    end
  end

  // Head entry is only exposed while issuing so idle outputs read as zero.
  assign WRITE_REQ    = (state_q == S_ISSUE);
  assign WRITE_ADDR   = WRITE_REQ ? {addr_mem[rd_ptr_q], 2'b00} : 32'h0;
  assign WRITE_DATA   = WRITE_REQ ? data_mem[rd_ptr_q] : 32'h0;
  assign BYTE_EN      = WRITE_REQ ? be_mem[rd_ptr_q] : 4'h0;
  assign BUFFER_EMPTY = empty_q;
  assign MISALIGNED   = mis_q;
  assign DBG_STATE    = state_q;
endmodule

// File: tb/tb_store_processing_unit.sv
// Directed bench for store_processing_unit with hand-computed expectations.
module tb_store_processing_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] address, data_in;
  logic        stall, misaligned, buffer_empty, write_req, mem_ack, dbg_state;
  logic [31:0] write_addr, write_data;
  logic [3:0]  byte_en;

  int total = 0;
  int bad = 0;

  store_processing_unit #(.DEPTH(2)) dut (
    .CLK(clk), .RESET(rst), .MEM_WRITE(mem_write), .FUNC3(func3),
    .ADDRESS(address), .DATA_IN(data_in), .STALL(stall),
    .MISALIGNED(misaligned), .BUFFER_EMPTY(buffer_empty),
    .WRITE_REQ(write_req), .WRITE_ADDR(write_addr), .WRITE_DATA(write_data),
    .BYTE_EN(byte_en), .MEM_ACK(mem_ack), .DBG_STATE(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1;
    func3     = f;
    address   = a;
    data_in   = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_write = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_write = 1'b0; func3 = 3'b000; address = '0; data_in = '0; mem_ack = 1'b0;
    do_reset();
    check("rst_req", {31'b0, write_req}, 32'd0);
    check("rst_empty", {31'b0, buffer_empty}, 32'd1);
    check("rst_mis", {31'b0, misaligned}, 32'd0);
    check("rst_addr", write_addr, 32'h0);
    check("rst_data", write_data, 32'h0);
    check("rst_be", {28'b0, byte_en}, 32'h0);

    // Scenario 1: SB at 0x1003
    mem_ack = 1'b1;
    present(3'b000, 32'h0000_1003, 32'h0000_00AB);
    tick();
    mem_write = 1'b0;
    check("s1_req_n", {31'b0, write_req}, 32'd0);
    check("s1_empty_n", {31'b0, buffer_empty}, 32'd0);
    tick();
    check("s1_req", {31'b0, write_req}, 32'd1);
    check("s1_addr", write_addr, 32'h0000_1000);
    check("s1_be", {28'b0, byte_en}, 32'h8);
    check("s1_data", write_data, 32'hABAB_ABAB);
    tick();
    check("s1_req_done", {31'b0, write_req}, 32'd0);
    check("s1_empty", {31'b0, buffer_empty}, 32'd1);

    // Scenario 2: SH at 0x2002 then SW at 0x2004
    mem_ack = 1'b0;
    present(3'b001, 32'h0000_2002, 32'hFFFF_1234);
    tick();
    present(3'b010, 32'h0000_2004, 32'hCAFE_F00D);
    tick();
    mem_write = 1'b0;
    check("s2_sh_addr", write_addr, 32'h0000_2000);
    check("s2_sh_be", {28'b0, byte_en}, 32'hC);
    check("s2_sh_data", write_data, 32'h1234_1234);
    tick();
    check("s2_hold_req", {31'b0, write_req}, 32'd1);
    check("s2_hold_data", write_data, 32'h1234_1234);
    mem_ack = 1'b1;
    tick();
    check("s2_sw_addr", write_addr, 32'h0000_2004);
    check("s2_sw_be", {28'b0, byte_en}, 32'hF);
    check("s2_sw_data", write_data, 32'hCAFE_F00D);
    tick();
    check("s2_idle", {31'b0, write_req}, 32'd0);

    // Scenario 3: three back-to-back SW with DEPTH=2
    mem_ack = 1'b0;
    present(3'b010, 32'h0000_0010, 32'h0000_0001);
    tick();
    present(3'b010, 32'h0000_0014, 32'h0000_0002);
    tick();
    present(3'b010, 32'h0000_0018, 32'h0000_0003);
    #1;
    check("s3_stall", {31'b0, stall}, 32'd1);
    check("s3_w0_addr", write_addr, 32'h0000_0010);
    mem_ack = 1'b1;
    #1;
    check("s3_stall_pop", {31'b0, stall}, 32'd1);
    tick();
    check("s3_w1_addr", write_addr, 32'h0000_0014);
    check("s3_unstall", {31'b0, stall}, 32'd0);
    tick();
    mem_write = 1'b0;
    check("s3_w2_addr", write_addr, 32'h0000_0018);
    check("s3_w2_data", write_data, 32'h0000_0003);
    tick();
    check("s3_idle", {31'b0, write_req}, 32'd0);
    check("s3_empty", {31'b0, buffer_empty}, 32'd1);

    // Scenario 4: SW at 0x3001
    present(3'b010, 32'h0000_3001, 32'h1122_3344);
    #1;
    check("s4_stall", {31'b0, stall}, 32'd0);
    tick();
    mem_write = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    check("s4_mis_pulse", {31'b0, misaligned}, 32'd1);
    check("s4_no_req0", {31'b0, write_req}, 32'd0);
    tick();
    check("s4_mis_clear", {31'b0, misaligned}, 32'd0);
    check("s4_no_req1", {31'b0, write_req}, 32'd0);
    check("s4_empty", {31'b0, buffer_empty}, 32'd1);
`else
    check("s4_mis_tied", {31'b0, misaligned}, 32'd0);
    tick();
    check("s4_req", {31'b0, write_req}, 32'd1);
    check("s4_addr", write_addr, 32'h0000_3000);
    check("s4_be", {28'b0, byte_en}, 32'hF);
    check("s4_data", write_data, 32'h1122_3344);
    tick();
`endif

    // Scenario 5: reset while issuing with two entries pending
    mem_ack = 1'b0;
    present(3'b010, 32'h0000_0040, 32'h0000_0040);
    tick();
    present(3'b010, 32'h0000_0044, 32'h0000_0044);
    tick();
    check("s5_issuing", {31'b0, write_req}, 32'd1);
    rst = 1'b1;
    present(3'b010, 32'h0000_0048, 32'h0000_0048);
    tick();
    rst = 1'b0;
    mem_write = 1'b0;
    check("s5_req", {31'b0, write_req}, 32'd0);
    check("s5_empty", {31'b0, buffer_empty}, 32'd1);
    check("s5_addr", write_addr, 32'h0);
    mem_ack = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (write_req) seen = 1'b1;
      end
      check("s5_no_later_write", {31'b0, seen}, 32'd0);
    end
    check("s5_empty_after", {31'b0, buffer_empty}, 32'd1);

    // Scenario 6: illegal FUNC3
    present(3'b011, 32'h0000_0050, 32'h0000_0050);
    #1;
    check("s6_stall", {31'b0, stall}, 32'd0);
    tick();
    check("s6_empty0", {31'b0, buffer_empty}, 32'd1);
    check("s6_mis", {31'b0, misaligned}, 32'd0);
    tick();
    mem_write = 1'b0;
    check("s6_no_req", {31'b0, write_req}, 32'd0);
    check("s6_empty1", {31'b0, buffer_empty}, 32'd1);
    mem_ack = 1'b0;
    present(3'b010, 32'h0000_0060, 32'h0);
    tick();
    present(3'b010, 32'h0000_0064, 32'h0);
    tick();
    present(3'b011, 32'h0000_0068, 32'h0);
    #1;
    check("s6_full_no_stall", {31'b0, stall}, 32'd0);
    mem_write = 1'b0;
    mem_ack = 1'b1;
    tick();
    tick();
    check("s6_drained", {31'b0, buffer_empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
